id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and MEM/WB operand forwarding.
// Registered instruction fields feed combinational forwarding and ALU operand muxes.
module id_ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [4:0]  id_wr_addr,
    input  logic [4:0]  id_shamt,
    input  logic [5:0]  id_alufun,
    input  logic        id_alusrc1,
    input  logic        id_alusrc2,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        mem_regwrite,
    input  logic        wb_regwrite,
    input  logic [4:0]  mem_wr_addr,
    input  logic [4:0]  wb_wr_addr,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,
    output logic [31:0] ex_alu_a,
    output logic [31:0] ex_alu_b,
    output logic [31:0] ex_store_data,
    output logic [5:0]  ex_alufun,
    output logic [4:0]  ex_wr_addr,
    output logic [31:0] ex_pc,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_valid,
    output logic        hazard_stall
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  wr_addr;
        logic [4:0]  shamt;
        logic [5:0]  alufun;
        logic        alusrc1;
        logic        alusrc2;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        valid;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t id_in;
    id_ex_t bubble_val;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        bubble_val    = '0;
        bubble_val.pc = RESET_PC;
    end

    always_comb begin
        id_in          = '0;
        id_in.pc       = id_pc;
        id_in.rs_data  = id_rs_data;
        id_in.rt_data  = id_rt_data;
        id_in.imm      = id_imm;
        id_in.rs_addr  = id_rs_addr;
        id_in.rt_addr  = id_rt_addr;
        id_in.wr_addr  = id_wr_addr;
        id_in.shamt    = id_shamt;
        id_in.alufun   = id_alufun;
        id_in.alusrc1  = id_alusrc1;
        id_in.alusrc2  = id_alusrc2;
        id_in.regwrite = id_regwrite;
        id_in.memread  = id_memread;
        id_in.memwrite = id_memwrite;
        id_in.valid    = 1'b1;
    end

    // A load in EX whose destination is read by the instruction in ID cannot be
    // forwarded in time; request a freeze upstream and insert a bubble here.
    assign hazard_stall = ex_q.memread & ex_q.valid & (ex_q.wr_addr != 5'd0) &
                          ((ex_q.wr_addr == id_rs_addr) | (ex_q.wr_addr == id_rt_addr));

    // Edge priority: stall holds everything (a concurrent flush is dropped),
    // then flush or load-use inserts a bubble, otherwise the ID fields load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= bubble_val;
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (flush || hazard_stall) begin
            ex_q <= bubble_val;
        end else begin
            ex_q <= id_in;
        end
    end

    // MEM is the younger producer, so it wins over WB; r0 is never forwarded.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (mem_regwrite && (mem_wr_addr != 5'd0) && (mem_wr_addr == ex_q.rs_addr)) begin
            fwd_rs = mem_result;
        end else if (wb_regwrite && (wb_wr_addr != 5'd0) && (wb_wr_addr == ex_q.rs_addr)) begin
            fwd_rs = wb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (mem_regwrite && (mem_wr_addr != 5'd0) && (mem_wr_addr == ex_q.rt_addr)) begin
            fwd_rt = mem_result;
        end else if (wb_regwrite && (wb_wr_addr != 5'd0) && (wb_wr_addr == ex_q.rt_addr)) begin
            fwd_rt = wb_result;
        end
    end

    assign ex_alu_a      = ex_q.alusrc1 ? {27'b0, ex_q.shamt} : fwd_rs;
    assign ex_alu_b      = ex_q.alusrc2 ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;

    assign ex_alufun   = ex_q.alufun;
    assign ex_wr_addr  = ex_q.wr_addr;
    assign ex_pc       = ex_q.pc;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_valid    = ex_q.valid;

endmodule
